// File: rtl/mod_pkg.sv
// Shared definitions for the repeated-subtraction modulo block: controller
// state encoding, datapath width and R-input select codes.
package mod_pkg;

    localparam int DP_W = 32;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/mod_iter_cnt.sv
// Subtraction counter: synchronous clear, increment enable, and a terminal
// count flag at MAX_ITER that also blocks any further increment.
module mod_iter_cnt #(
    parameter int                ITER_W   = 32,
    parameter logic [ITER_W-1:0] MAX_ITER = {ITER_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ITER_W-1:0] cnt,
    output logic              tc
);

    localparam logic [ITER_W-1:0] CNT_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    logic [ITER_W-1:0] cnt_r;

    // Count register; the terminal compare gates the increment so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {ITER_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {ITER_W{1'b0}};
        end else if (inc && !tc) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == MAX_ITER);

endmodule

// File: rtl/mod_ctrl.sv
// Sequencer for the repeated-subtraction modulo datapath: loads A, subtracts B
// while B <= R, counts the subtractions, and aborts at the iteration limit.
module mod_ctrl
    import mod_pkg::*;
#(
    parameter int                ITER_W   = 32,
    parameter logic [ITER_W-1:0] MAX_ITER = {ITER_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sub_ok,
    output logic              ld,
    output logic              mux,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] quo
);

    state_t state_r;
    state_t state_s;
    logic   ld_s;
    logic   clr_s;
    logic   inc_s;
    logic   tc_s;
    logic   mux_r;
    logic   busy_r;
    logic   done_r;
    logic   err_r;

    assign clr_s = (state_r == ST_IDLE) && start;
    assign inc_s = (state_r == ST_RUN) && sub_ok && !tc_s;

    mod_iter_cnt #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .inc   (inc_s),
        .cnt   (quo),
        .tc    (tc_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and the R load enable (the only input-to-output path, in RUN).
    always_comb begin
        state_s = state_r;
        ld_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ld_s    = 1'b1;
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (!sub_ok) begin
                    state_s = ST_DONE;
                end else if (tc_s) begin
                    state_s = ST_ERR;
                end else begin
                    ld_s    = 1'b1;
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so they equal a clean state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_r  <= SEL_A;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            mux_r  <= (state_s == ST_RUN) ? SEL_SUB : SEL_A;
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE) || (state_s == ST_ERR);
            if (clr_s) begin
                err_r <= 1'b0;
            end else if (state_s == ST_ERR) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign ld   = ld_s;
    assign mux  = mux_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_mod_ctrl.sv
// Bench for mod_ctrl: two instances (MAX_ITER 8 and 15) share stimulus, each
// drives its own R register; a per-operation timeline model is checked each cycle.
module tb_mod_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_op;
    logic [31:0] b_op;
    logic [31:0] r_a, r_b;
    logic        ld_a, mux_a, busy_a, done_a, err_a;
    logic        ld_b, mux_b, busy_b, done_b, err_b;
    logic [7:0]  quo_a;
    logic [3:0]  quo_b;
    logic        sub_ok_a, sub_ok_b;

    int n_cmp = 0;
    int n_fail = 0;
    int max_of[2] = '{8, 15};

    always #5 clk = ~clk;

    assign sub_ok_a = (b_op <= r_a);
    assign sub_ok_b = (b_op <= r_b);

    mod_ctrl #(.ITER_W(8), .MAX_ITER(8'd8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .sub_ok(sub_ok_a),
        .ld(ld_a), .mux(mux_a), .busy(busy_a), .done(done_a), .err(err_a), .quo(quo_a)
    );

    mod_ctrl #(.ITER_W(4), .MAX_ITER(4'd15)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .sub_ok(sub_ok_b),
        .ld(ld_b), .mux(mux_b), .busy(busy_b), .done(done_b), .err(err_b), .quo(quo_b)
    );

    // Datapath stand-ins: R loads A or R-B under the controller's ld/mux.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 32'd0;
            r_b <= 32'd0;
        end else begin
            if (ld_a) r_a <= mux_a ? (r_a - b_op) : a_op;
            if (ld_b) r_b <= mux_b ? (r_b - b_op) : a_op;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted operation is a timeline of q+3 busy cycles, where q is
    // A/B, or MAX (with error) if B = 0 or A/B exceeds MAX.
    bit m_idle[2];
    int m_k[2], m_q[2], m_quo[2];
    bit m_e[2], m_err[2];

    function automatic int exp_q(input int mx);
        longint unsigned qq;
        if (b_op == 32'd0) return mx;
        qq = a_op / b_op;
        if (qq > longint'(mx)) return mx;
        return int'(qq);
    endfunction

    function automatic bit exp_e(input int mx);
        if (b_op == 32'd0) return 1'b1;
        return (longint'(a_op / b_op) > longint'(mx));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_idle[i] <= 1'b1; m_k[i] <= 0; m_q[i] <= 0;
                m_quo[i]  <= 0;    m_e[i] <= 1'b0; m_err[i] <= 1'b0;
            end else if (m_idle[i]) begin
                if (start) begin
                    m_idle[i] <= 1'b0; m_k[i] <= 0;
                    m_q[i] <= exp_q(max_of[i]); m_e[i] <= exp_e(max_of[i]);
                    m_err[i] <= 1'b0; m_quo[i] <= 0;
                end
            end else begin
                m_k[i] <= m_k[i] + 1;
                if (m_k[i] + 1 == m_q[i] + 2) begin
                    m_err[i] <= m_e[i];
                    m_quo[i] <= m_q[i];
                end
                if (m_k[i] + 1 == m_q[i] + 3) m_idle[i] <= 1'b1;
            end
        end
    end

    task automatic model_out(input int i, output bit eb, output bit el, output bit em,
                             output bit ed, output bit ee, output int eq);
        int k;
        k = m_k[i];
        ee = m_err[i];
        if (m_idle[i]) begin
            eb = 0; el = 0; em = 0; ed = 0; eq = m_quo[i];
        end else if (k == 0) begin
            eb = 1; el = 1; em = 0; ed = 0; eq = 0;
        end else if (k <= m_q[i] + 1) begin
            eb = 1; el = (k <= m_q[i]); em = 1; ed = 0; eq = k - 1;
        end else begin
            eb = 1; el = 0; em = 0; ed = 1; eq = m_q[i];
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        bit eb, el, em, ed, ee;
        int eq;
        if (rst_n) begin
            model_out(0, eb, el, em, ed, ee, eq);
            chk("a.busy", busy_a, eb); chk("a.ld", ld_a, el); chk("a.mux", mux_a, em);
            chk("a.done", done_a, ed); chk("a.err", err_a, ee); chk("a.quo", quo_a, eq);
            model_out(1, eb, el, em, ed, ee, eq);
            chk("b.busy", busy_b, eb); chk("b.ld", ld_b, el); chk("b.mux", mux_b, em);
            chk("b.done", done_b, ed); chk("b.err", err_b, ee); chk("b.quo", quo_b, eq);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a_outs"}, {ld_a, mux_a, busy_a, done_a, err_a}, 5'd0);
        chk({tag, ".a_quo"}, quo_a, 0);
        chk({tag, ".b_outs"}, {ld_b, mux_b, busy_b, done_b, err_b}, 5'd0);
        chk({tag, ".b_quo"}, quo_b, 0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL idle_timeout: busy still high after 300 cycles");
        end
    endtask

    // One operation observed on instance sel (0 = a, 1 = b); poke >= 0 pulses
    // start again on that cycle of the operation.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int lat, output int ldc, output int bsy,
                          output int quo, output int rem, output bit err_done, output bit err_load);
        a_op = a; b_op = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; ldc = 0; bsy = 0; quo = -1; rem = -1; err_done = 0; err_load = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == poke + 1) start = 1'b0;
            if (i == 0) err_load = sel ? err_b : err_a;
            if (sel ? ld_b : ld_a) ldc++;
            if (sel ? busy_b : busy_a) bsy++;
            if (sel ? done_b : done_a) begin
                lat = i;
                quo = sel ? int'(quo_b) : int'(quo_a);
                rem = sel ? int'(r_b) : int'(r_a);
                err_done = sel ? err_b : err_a;
                break;
            end
            if (i == poke) start = 1'b1;
        end
        if (lat < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done within 300 cycles (A=%0d B=%0d)", a, b);
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ldc, bsy, quo, rem, dcnt, sel, mx, q, poke;
        bit ed, el;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; a_op = 32'd0; b_op = 32'd1;
        #3 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Nominal 17 mod 5.
        run_op(1, 17, 5, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("nom.lat", lat, 5); chk("nom.ld", ldc, 4); chk("nom.busy", bsy, 6);
        chk("nom.quo", quo, 3); chk("nom.rem", rem, 2); chk("nom.err", ed, 0);

        // A < B, A == B, A == 0.
        run_op(1, 3, 7, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("altb.lat", lat, 2); chk("altb.quo", quo, 0); chk("altb.rem", rem, 3);
        run_op(1, 5, 5, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("aeqb.quo", quo, 1); chk("aeqb.rem", rem, 0);
        run_op(0, 0, 1, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("azero.quo", quo, 0); chk("azero.rem", rem, 0);

        // Divide by zero against MAX_ITER = 8.
        run_op(0, 42, 0, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("dz.quo", quo, 8); chk("dz.err", ed, 1); chk("dz.ld", ldc, 9);
        chk("dz.lat", lat, 10); chk("dz.rem", rem, 42);
        repeat (3) @(negedge clk);
        chk("dz.err_sticky", err_a, 1);

        // Counter ceiling with ITER_W = 4; also clears the sticky err above.
        run_op(1, 16, 1, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("ceil.quo", quo, 15); chk("ceil.err", ed, 1); chk("ceil.ld", ldc, 16);
        chk("ceil.rem", rem, 1);
        run_op(0, 10, 3, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("clr.err_load", el, 0); chk("clr.quo", quo, 3);

        // start pulsed during RUN is ignored.
        run_op(1, 20, 2, 3, lat, ldc, bsy, quo, rem, ed, el);
        chk("poke.quo", quo, 10); chk("poke.lat", lat, 12); chk("poke.rem", rem, 0);

        // Asynchronous reset after 10 RUN cycles.
        a_op = 1000; b_op = 3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_op(1, 10, 3, -1, lat, ldc, bsy, quo, rem, ed, el);
        chk("postrst.quo", quo, 3); chk("postrst.rem", rem, 1); chk("postrst.err", ed, 0);

        // start held high: one op every q+4 = 7 cycles.
        a_op = 7; b_op = 2; start = 1'b1;
        @(posedge clk);
        dcnt = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (done_b) dcnt++;
            if (i == 27) start = 1'b0;
        end
        chk("b2b.dones", dcnt, 4);
        wait_idle();

        // Randomized operations checked against plain arithmetic.
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(1, 0);
            mx   = max_of[sel];
            ra   = $urandom_range(100, 0);
            rb   = $urandom_range(10, 0);
            poke = ($urandom_range(1, 0) == 1) ? 1 : -1;
            q    = (rb == 0 || (ra / rb) > mx) ? mx : int'(ra / rb);
            run_op(sel, ra, rb, poke, lat, ldc, bsy, quo, rem, ed, el);
            chk("rnd.lat", lat, q + 2); chk("rnd.ld", ldc, q + 1); chk("rnd.busy", bsy, q + 3);
            chk("rnd.quo", quo, q); chk("rnd.rem", rem, int'(ra) - q * int'(rb));
            chk("rnd.err", ed, (rb == 0 || (ra / rb) > mx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
